multicycle_control_fsm: RTL and testbench

- Multi-cycle sequencer for the RV32I subset core: lw, sw, R-type, I-type ALU, beq, jal.
- Replaces the single-cycle combinational decoder path. Steps shared PC/ALU/memory datapath through fetch, decode, execute, memory and writeback states.
- Stalls on a ready/request memory handshake, with a watchdog on that handshake.
- Counts retired instructions.

---
 rtl/multicycle_control_fsm.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: multi-cycle RV32I sequencer (lw, sw, R/I ALU, beq, jal)
// with a memory handshake watchdog and a retired-instruction counter.
module multicycle_control_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state_dbg
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam int         WW     = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              req_st, abort, retire;
    logic [2:0]        alu_op;
    logic              unused_f7;

    assign unused_f7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        req_st  = state_q inside {FETCH, MEMREAD, MEMWRITE};
        // A ready arriving in the timeout cycle still completes the access
        abort   = req_st && wait_q == WW'(TIMEOUT_CYCLES) && !mem_ready;
        alu_op  = funct3 == 3'b010 ? 3'b101 :
                  funct3 == 3'b110 ? 3'b011 :
                  funct3 == 3'b111 ? 3'b010 :
                  (funct3 == 3'b000 && state_q == EXECR && funct7[5]) ? 3'b001 : 3'b000;
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE:   state_d = (Op == OP_LW || Op == OP_SW) ? MEMADR :
                                Op == OP_R   ? EXECR :
                                Op == OP_I   ? EXECI :
                                Op == OP_BEQ ? BEQ   :
                                Op == OP_JAL ? JAL   : TRAP;
            MEMADR:   state_d = Op == OP_SW ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            JAL:      state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
        if (abort) state_d = FETCH;
        retire    = state_d == FETCH &&
                    (state_q inside {MEMWB, ALUWB, BEQ} || (state_q == MEMWRITE && mem_ready));
        wait_d    = (state_d != state_q || abort) ? '0 :
                    (req_st && !mem_ready) ? wait_q + 1'b1 : wait_q;
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        mem_req       = 1'b0;
        MemWrite      = 1'b0;
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        ImmSrc        = 2'b00;
        ALUControl    = 3'b000;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        if (!rst) begin
            bus_error = abort;
            case (state_q)
                FETCH: begin
                    mem_req   = !abort;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    ALUSrcB   = mem_ready ? 2'b10 : 2'b00;
                    ResultSrc = mem_ready ? 2'b10 : 2'b00;
                end
                DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = 2'b10;
                end
                MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = Op == OP_SW ? 2'b01 : 2'b00;
                end
                MEMREAD: begin
                    mem_req = !abort;
                    AdrSrc  = !abort;
                end
                MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                MEMWRITE: begin
                    mem_req  = !abort;
                    MemWrite = !abort;
                    AdrSrc   = !abort;
                end
                EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = alu_op;
                end
                EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_op;
                end
                ALUWB:   RegWrite = 1'b1;
                BEQ: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = 3'b001;
                    PCWrite    = Zero;
                end
                JAL: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    PCWrite = 1'b1;
                end
                TRAP:    illegal_instr = 1'b1;
                default: ;
            endcase
        end
    end

    assign instret   = instret_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: cycle vectors of {inputs, expected state/controls/instret}
// pushed to a scoreboard on drive and checked mid-cycle.
module tb_multicycle_control_fsm;
    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b;
        logic        zero;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [31:0] ir;
    } vec_t;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;
    // {req,mw,adr,irw,pcw,rw} {A,B,Res,Imm} {alu} {ill,be}
    localparam logic [18:0] F_RDY = {6'b100110, 2'b00, 2'b10, 2'b10, 2'b00, 3'b000, 2'b00};
    localparam logic [18:0] F_WT  = {6'b100000, 8'b0, 3'b000, 2'b00};
    localparam logic [18:0] DEC   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b10, 3'b000, 2'b00};
    localparam logic [18:0] AWB   = {6'b000001, 8'b0, 3'b000, 2'b00};
    localparam logic [18:0] MWB   = {6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00};
    localparam logic [18:0] MRD   = {6'b101000, 8'b0, 3'b000, 2'b00};
    localparam logic [18:0] MWR   = {6'b111000, 8'b0, 3'b000, 2'b00};
    localparam logic [18:0] JALC  = {6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [18:0] TRP   = 19'b10;
    localparam logic [18:0] BE    = 19'b01;
    localparam logic [18:0] NONE  = 19'b0;

    logic clk = 1'b0, rst = 1'b1, Zero = 1'b0, mem_ready = 1'b0;
    logic [6:0] Op = 7'b0, funct7 = 7'b0;
    logic [2:0] funct3 = 3'b0;
    logic mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal_instr, bus_error;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;
    logic [31:0] instret;
    logic [3:0] state_dbg;
    logic [18:0] ctl_act;

    vec_t tbl[$];
    vec_t sb[$];
    int n_vec = 0, n_miss = 0;
    logic [31:0] ir;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .illegal_instr(illegal_instr), .bus_error(bus_error), .instret(instret),
        .state_dbg(state_dbg)
    );

    assign ctl_act = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
                      ResultSrc, ImmSrc, ALUControl, illegal_instr, bus_error};

    function automatic logic [18:0] exr(input logic [2:0] alu);
        return {6'b0, 2'b10, 2'b00, 2'b00, 2'b00, alu, 2'b00};
    endfunction
    function automatic logic [18:0] exi(input logic [2:0] alu);
        return {6'b0, 2'b10, 2'b01, 2'b00, 2'b00, alu, 2'b00};
    endfunction
    function automatic logic [18:0] madr(input logic [1:0] imm);
        return {6'b0, 2'b10, 2'b01, 2'b00, imm, 3'b000, 2'b00};
    endfunction
    function automatic logic [18:0] beqc(input logic z);
        return {4'b0, z, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 2'b00};
    endfunction

    function automatic vec_t mk(input logic r, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7b, input logic z, input logic rdy,
                                input logic [3:0] st, input logic [18:0] ctl, input logic [31:0] n);
        vec_t v;
        v.rst = r; v.op = op; v.f3 = f3; v.f7b = f7b; v.zero = z; v.rdy = rdy;
        v.st = st; v.ctl = ctl; v.ir = n;
        return v;
    endfunction

    function automatic void row(input logic [6:0] op, input logic [2:0] f3, input logic f7b,
                                input logic z, input logic [3:0] st, input logic [18:0] ctl,
                                input logic [31:0] n);
        tbl.push_back(mk(1'b0, op, f3, f7b, z, 1'b1, st, ctl, n));
    endfunction

    task automatic apply(input vec_t v);
        vec_t e;
        rst = v.rst; Op = v.op; funct3 = v.f3; funct7 = {1'b0, v.f7b, 5'b0};
        Zero = v.zero; mem_ready = v.rdy;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        n_vec++;
        if (state_dbg !== e.st) begin
            n_miss++;
            $display("FAIL vec%0d state: got %0d want %0d", n_vec, state_dbg, e.st);
        end
        if (ctl_act !== e.ctl) begin
            n_miss++;
            $display("FAIL vec%0d controls: got %b want %b", n_vec, ctl_act, e.ctl);
        end
        if (instret !== e.ir) begin
            n_miss++;
            $display("FAIL vec%0d instret: got %0d want %0d", n_vec, instret, e.ir);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        row(R, 3'b000, 0, 0, 0, F_RDY, 0);  row(R, 3'b000, 0, 0, 1, DEC, 0);
        row(R, 3'b000, 0, 0, 6, exr(3'b000), 0);  row(R, 3'b000, 0, 0, 8, AWB, 0);
        row(R, 3'b000, 1, 0, 0, F_RDY, 1);  row(R, 3'b000, 1, 0, 1, DEC, 1);
        row(R, 3'b000, 1, 0, 6, exr(3'b001), 1);  row(R, 3'b000, 1, 0, 8, AWB, 1);
        row(I, 3'b010, 0, 0, 0, F_RDY, 2);  row(I, 3'b010, 0, 0, 1, DEC, 2);
        row(I, 3'b010, 0, 0, 7, exi(3'b101), 2);  row(I, 3'b010, 0, 0, 8, AWB, 2);
        row(R, 3'b111, 1, 0, 0, F_RDY, 3);  row(R, 3'b111, 1, 0, 1, DEC, 3);
        row(R, 3'b111, 1, 0, 6, exr(3'b010), 3);  row(R, 3'b111, 1, 0, 8, AWB, 3);
        row(I, 3'b110, 0, 0, 0, F_RDY, 4);  row(I, 3'b110, 0, 0, 1, DEC, 4);
        row(I, 3'b110, 0, 0, 7, exi(3'b011), 4);  row(I, 3'b110, 0, 0, 8, AWB, 4);
        row(I, 3'b000, 1, 0, 0, F_RDY, 5);  row(I, 3'b000, 1, 0, 1, DEC, 5);
        row(I, 3'b000, 1, 0, 7, exi(3'b000), 5);  row(I, 3'b000, 1, 0, 8, AWB, 5);
        row(R, 3'b001, 0, 0, 0, F_RDY, 6);  row(R, 3'b001, 0, 0, 1, DEC, 6);
        row(R, 3'b001, 0, 0, 6, exr(3'b000), 6);  row(R, 3'b001, 0, 0, 8, AWB, 6);
        row(SW, 3'b010, 0, 0, 0, F_RDY, 7); row(SW, 3'b010, 0, 0, 1, DEC, 7);
        row(SW, 3'b010, 0, 0, 2, madr(2'b01), 7); row(SW, 3'b010, 0, 0, 5, MWR, 7);
        row(LW, 3'b010, 0, 0, 0, F_RDY, 8); row(LW, 3'b010, 0, 0, 1, DEC, 8);
        row(LW, 3'b010, 0, 0, 2, madr(2'b00), 8); row(LW, 3'b010, 0, 0, 3, MRD, 8);
        row(LW, 3'b010, 0, 0, 4, MWB, 8);
        row(BQ, 3'b000, 0, 1, 0, F_RDY, 9); row(BQ, 3'b000, 0, 1, 1, DEC, 9);
        row(BQ, 3'b000, 0, 1, 9, beqc(1'b1), 9);
        row(BQ, 3'b000, 0, 0, 0, F_RDY, 10); row(BQ, 3'b000, 0, 0, 1, DEC, 10);
        row(BQ, 3'b000, 0, 0, 9, beqc(1'b0), 10);
        row(JL, 3'b000, 0, 0, 0, F_RDY, 11); row(JL, 3'b000, 0, 0, 1, DEC, 11);
        row(JL, 3'b000, 0, 0, 10, JALC, 11); row(JL, 3'b000, 0, 0, 8, AWB, 11);
        row(BAD, 3'b000, 0, 0, 0, F_RDY, 12); row(BAD, 3'b000, 0, 0, 1, DEC, 12);
        row(BAD, 3'b000, 0, 0, 11, TRP, 12);

        @(posedge clk);
        #1;
        apply(mk(1, R, 3'b0, 0, 0, 1, 0, NONE, 0));
        foreach (tbl[i]) apply(tbl[i]);
        ir = 12;

        // fetch never answered: bus_error after 16 wait cycles, then a clean add
        for (int i = 0; i < 16; i++) apply(mk(0, R, 3'b0, 0, 0, 0, 0, F_WT, ir));
        apply(mk(0, R, 3'b0, 0, 0, 0, 0, BE, ir));
        apply(mk(0, R, 3'b0, 0, 0, 1, 0, F_RDY, ir));
        apply(mk(0, R, 3'b0, 0, 0, 1, 1, DEC, ir));
        apply(mk(0, R, 3'b0, 0, 0, 1, 6, exr(3'b000), ir));
        apply(mk(0, R, 3'b0, 0, 0, 1, 8, AWB, ir));
        ir++;

        // store times out: no retire
        apply(mk(0, SW, 3'b0, 0, 0, 1, 0, F_RDY, ir));
        apply(mk(0, SW, 3'b0, 0, 0, 1, 1, DEC, ir));
        apply(mk(0, SW, 3'b0, 0, 0, 1, 2, madr(2'b01), ir));
        for (int i = 0; i < 16; i++) apply(mk(0, SW, 3'b0, 0, 0, 0, 5, MWR, ir));
        apply(mk(0, SW, 3'b0, 0, 0, 0, 5, BE, ir));

        // load: ready arrives exactly in the timeout cycle and wins
        apply(mk(0, LW, 3'b0, 0, 0, 1, 0, F_RDY, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 1, DEC, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 2, madr(2'b00), ir));
        for (int i = 0; i < 16; i++) apply(mk(0, LW, 3'b0, 0, 0, 0, 3, MRD, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 3, MRD, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 4, MWB, ir));
        ir++;

        // reset while a load is waiting in MEMREAD
        apply(mk(0, LW, 3'b0, 0, 0, 1, 0, F_RDY, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 1, DEC, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 2, madr(2'b00), ir));
        apply(mk(0, LW, 3'b0, 0, 0, 0, 3, MRD, ir));
        ir = 0;
        apply(mk(1, LW, 3'b0, 0, 0, 0, 0, NONE, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 0, 0, F_WT, ir));

        // lw with 3 fetch waits and 2 read waits: 10 cycles total
        apply(mk(0, LW, 3'b0, 0, 0, 0, 0, F_WT, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 0, 0, F_WT, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 0, F_RDY, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 1, DEC, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 2, madr(2'b00), ir));
        apply(mk(0, LW, 3'b0, 0, 0, 0, 3, MRD, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 0, 3, MRD, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 3, MRD, ir));
        apply(mk(0, LW, 3'b0, 0, 0, 1, 4, MWB, ir));
        ir++;
        apply(mk(0, LW, 3'b0, 0, 0, 0, 0, F_WT, ir));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
